function4x1_scan_controller: RTL and testbench

Sequencer that drives a 4-input combinational function block (function4x1) through all 16 input combinations. It samples output f for each combination and assembles a 16-bit truth table. The table is compared against an expected pattern latched at start. The block sits between the lab's top level (switches and LEDs, or a bench) and the function block, replacing the hand-written stimulus sequence with a self-checking hardware scan.

---
 rtl/function_scan_pkg.sv | 16 +
 rtl/scan_settle_timer.sv | 27 ++
 rtl/function4x1_scan_controller.sv | 156 +++++++++++++++
 tb/tb_function4x1_scan_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/function_scan_pkg.sv
// Shared constants and state encoding for the function4x1 truth-table scanner.
package function_scan_pkg;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned SETTLE_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter that times the settle gap between input change and sampling.
module scan_settle_timer
    import function_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                zero_c
);

    logic [SETTLE_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - SETTLE_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/function4x1_scan_controller.sv
// Walks a 4-input function block through all 16 input codes, captures f into a
// truth table and compares it with a golden pattern latched at start.
module function4x1_scan_controller
    import function_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      expected,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             f,
    output logic             busy,
    output logic             done,
    output logic [15:0]      truth_table,
    output logic             match,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [IDX_W-1:0] first_fail
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);
    // With no settle time every step goes straight back to sampling.
    localparam state_t STEP_STATE = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] abcd;
    logic [15:0]      expected_q;
    logic             timer_load;
    logic             timer_en;
    logic             timer_zero;
    logic             last_idx;
    logic             f_miss;

    assign last_idx = (idx == IDX_W'(NUM_VECTORS - 1));
    assign f_miss   = (f != expected_q[idx]);

    scan_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (SETTLE_LOAD),
        .zero_c   (timer_zero)
    );

    // Next-state and timer control.
    always_comb begin
        state_d    = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = STEP_STATE;
                    timer_load = 1'b1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (timer_zero) begin
                    state_d = S_SAMPLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = STEP_STATE;
                    timer_load = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            idx            <= '0;
            abcd           <= '0;
            expected_q     <= '0;
            truth_table    <= '0;
            match          <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
        end else begin
            state <= state_d;
            busy  <= (state_d != S_IDLE);
            done  <= (state == S_SAMPLE) && (state_d == S_DONE);
            case (state)
                S_IDLE: begin
                    if (state_d != S_IDLE) begin
                        idx            <= '0;
                        abcd           <= '0;
                        expected_q     <= expected;
                        truth_table    <= '0;
                        match          <= 1'b0;
                        mismatch_count <= '0;
                        first_fail     <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        abcd  <= '0;
                        match <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        abcd  <= '0;
                        match <= 1'b0;
                    end else begin
                        truth_table[idx] <= f;
                        if (f_miss) begin
                            mismatch_count <= mismatch_count + CNT_W'(1);
                            if (mismatch_count == '0) begin
                                first_fail <= idx;
                            end
                        end
                        // match must be valid alongside the done pulse, so fold in this sample.
                        if (last_idx) begin
                            match <= (mismatch_count == '0) && !f_miss;
                        end else begin
                            idx  <= idx + IDX_W'(1);
                            abcd <= idx + IDX_W'(1);
                        end
                    end
                end
                S_DONE: abcd <= '0;
                default: abcd <= '0;
            endcase
        end
    end

    assign a = abcd[3];
    assign b = abcd[2];
    assign c = abcd[1];
    assign d = abcd[0];

endmodule

// File: tb/tb_function4x1_scan_controller.sv
// Scoreboard bench: two scanner instances (settle 1 and settle 0) driving a modelled f.
module tb_function4x1_scan_controller;

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic [4:0]  cnt;
        logic [3:0]  ff;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s [2];
    logic        abort_s [2];
    logic [15:0] exp_s   [2];
    logic        a_s     [2];
    logic        b_s     [2];
    logic        c_s     [2];
    logic        d_s     [2];
    logic        f_s     [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [15:0] tt_s    [2];
    logic        match_s [2];
    logic [4:0]  cnt_s   [2];
    logic [3:0]  ff_s    [2];
    int          f_mode  [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // mode 0: f = a ^ d, mode 1: f tied high
    assign f_s[0] = (f_mode[0] != 0) ? 1'b1 : (a_s[0] ^ d_s[0]);
    assign f_s[1] = (f_mode[1] != 0) ? 1'b1 : (a_s[1] ^ d_s[1]);

    function4x1_scan_controller #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .expected(exp_s[0]), .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .d(d_s[0]),
        .f(f_s[0]), .busy(busy_s[0]), .done(done_s[0]), .truth_table(tt_s[0]),
        .match(match_s[0]), .mismatch_count(cnt_s[0]), .first_fail(ff_s[0])
    );

    function4x1_scan_controller #(.SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .expected(exp_s[1]), .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .d(d_s[1]),
        .f(f_s[1]), .busy(busy_s[1]), .done(done_s[1]), .truth_table(tt_s[1]),
        .match(match_s[1]), .mismatch_count(cnt_s[1]), .first_fail(ff_s[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] abcd(input int s);
        return {a_s[s], b_s[s], c_s[s], d_s[s]};
    endfunction

    function automatic exp_t model(input int mode, input logic [15:0] golden);
        exp_t e;
        logic [3:0] iv;
        logic fv;
        e.tt = '0; e.cnt = '0; e.ff = '0;
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            fv = (mode != 0) ? 1'b1 : (iv[3] ^ iv[0]);
            e.tt[i] = fv;
            if (fv != golden[i]) begin
                if (e.cnt == 0) e.ff = iv;
                e.cnt = e.cnt + 5'd1;
            end
        end
        e.match = (e.cnt == 0);
        return e;
    endfunction

    task automatic pulse_start(input int s);
        @(negedge clk);
        start_s[s] = 1'b1;
        @(posedge clk);
        #1 start_s[s] = 1'b0;
    endtask

    // Full scan; optional start re-pulse / expected change at cycle restart_at.
    task automatic run_scan(input int s, input int mode, input logic [15:0] golden,
                            input int restart_at, input bit change_exp);
        int   settle = (s == 0) ? 1 : 0;
        int   n = 0;
        int   extra = 0;
        bit   seq_ok = 1'b1;
        bit   seen = 1'b0;
        exp_t e;
        f_mode[s] = mode;
        exp_s[s]  = golden;
        sb.push_back(model(mode, golden));
        pulse_start(s);
        while (n < 16 * (settle + 1) + 8) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_s[s]) begin
                seen = 1'b1;
                break;
            end
            if (abcd(s) != 4'(n / (settle + 1)) || !busy_s[s]) seq_ok = 1'b0;
            if (n == restart_at) begin
                start_s[s] = 1'b1;
                if (change_exp) exp_s[s] = ~golden;
            end else begin
                start_s[s] = 1'b0;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        if (seen) begin
            check("latency", 32'(n), 32'(16 * (settle + 1)));
            check("abcd_seq", 32'(seq_ok), 32'd1);
            check("truth_table", 32'(tt_s[s]), 32'(e.tt));
            check("match", 32'(match_s[s]), 32'(e.match));
            check("mismatch_count", 32'(cnt_s[s]), 32'(e.cnt));
            check("first_fail", 32'(ff_s[s]), 32'(e.ff));
            // start during DONE must be ignored
            start_s[s] = 1'b1;
            @(negedge clk);
            start_s[s] = 1'b0;
            check("idle_after_done", {31'd0, busy_s[s]}, 32'd0);
            check("abcd_after_done", 32'(abcd(s)), 32'd0);
            for (int k = 0; k < 40; k++) begin
                if (done_s[s] || busy_s[s]) extra++;
                @(negedge clk);
            end
            check("single_done", 32'(extra), 32'd0);
            check("match_held", 32'(match_s[s]), 32'(e.match));
        end
    endtask

    initial begin
        logic [15:0] ref0;
        int n;
        int extra;
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0; abort_s[s] = 1'b0; exp_s[s] = '0; f_mode[s] = 0;
        end
        ref0 = model(0, 16'h0000).tt;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_tt", 32'(tt_s[0]), 32'd0);
        check("rst_outs", {22'd0, done_s[0], match_s[0], cnt_s[0], ff_s[0]}, 32'd0);
        check("rst_dut1", {15'd0, busy_s[1], tt_s[1], abcd(1)}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(0, 0, ref0, 0, 1'b0);
        run_scan(0, 0, ref0 ^ 16'h0002, 0, 1'b0);
        run_scan(1, 1, 16'h0000, 0, 1'b0);
        run_scan(0, 0, ref0, 9, 1'b1);

        // Abort in the SAMPLE cycle of index 6
        f_mode[0] = 1;
        exp_s[0]  = 16'h0000;
        pulse_start(0);
        n = 0;
        while (n < 13) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_busy", 32'(busy_s[0]), 32'd0);
        check("abort_abcd", 32'(abcd(0)), 32'd0);
        check("abort_match", {30'd0, match_s[0], done_s[0]}, 32'd0);
        check("abort_tt", 32'(tt_s[0]), 32'h003F);
        check("abort_cnt", 32'(cnt_s[0]), 32'd6);
        check("abort_ff", 32'(ff_s[0]), 32'd0);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_s[0] || busy_s[0]) extra++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(extra), 32'd0);

        // Asynchronous reset during SETTLE of index 2
        f_mode[0] = 0;
        exp_s[0]  = 16'h0000;
        pulse_start(0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_cnt", 32'(cnt_s[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy_s[0]}, 32'd0);
        check("async_rst_abcd", 32'(abcd(0)), 32'd0);
        check("async_rst_res", {5'd0, tt_s[0], match_s[0], cnt_s[0], ff_s[0], done_s[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(0, 0, ref0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
